// File: rtl/noc_sa_pkg.sv
// Shared switch-allocator definitions: port/VC counts, allocator state encoding
// and the default stall-counter width.
package noc_sa_pkg;

  localparam int NOC_N       = 5;
  localparam int NOC_V       = 2;
  localparam int NOC_STALL_W = 16;

  typedef enum logic {
    SA_IDLE   = 1'b0,
    SA_LOCKED = 1'b1
  } sa_state_e;

endpackage

// File: rtl/sa_oport_arb_if.sv
// Request/grant bundle between the input-port stages and one output-port arbiter.
interface sa_oport_arb_if #(
  parameter int N = noc_sa_pkg::NOC_N
);

  logic [N-1:0] req_in;
  logic [N-1:0] tail_in;
  logic         credit_ok;
  logic [N-1:0] grant_out;
  logic         grant_valid;
  logic         locked_out;
  logic [N-1:0] owner_out;

  modport master (
    output req_in, tail_in, credit_ok,
    input  grant_out, grant_valid, locked_out, owner_out
  );

  modport slave (
    input  req_in, tail_in, credit_ok,
    output grant_out, grant_valid, locked_out, owner_out
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: returns the first request at or above the
// one-hot pointer, wrapping from N-1 back to 0.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] ptr,
  output logic [N-1:0] gnt
);

  logic [N-1:0]   mask;
  logic [2*N-1:0] dreq;
  logic [2*N-1:0] dgnt;

  // Low half holds requests at/above ptr, high half the full vector for wrap;
  // isolating the lowest set bit of the concatenation gives the winner.
  always_comb begin
    mask = ~(ptr - N'(1));
    dreq = {req, req & mask};
    dgnt = dreq & (~dreq + (2*N)'(1));
    gnt  = dgnt[N-1:0] | dgnt[2*N-1:N];
  end

endmodule

// File: rtl/sa_oport_arb.sv
// Output-port switch-allocator stage: round-robin among input requests with a
// wormhole lock until the tail flit. Define SA_OPORT_STALL_CNT_EN for stall_cnt.
module sa_oport_arb
  import noc_sa_pkg::*;
#(
  parameter int N = NOC_N
`ifdef SA_OPORT_STALL_CNT_EN
  ,
  parameter int STALL_W = NOC_STALL_W
`endif
) (
  input  logic                clk,
  input  logic                rstn,
  sa_oport_arb_if.slave       bus
`ifdef SA_OPORT_STALL_CNT_EN
  ,
  output logic [STALL_W-1:0]  stall_cnt
`endif
);

  sa_state_e    state_q, state_d;
  logic [N-1:0] ptr_q, ptr_d;
  logic [N-1:0] owner_q, owner_d;
  logic [N-1:0] pick;
  logic [N-1:0] grant;

  function automatic logic [N-1:0] rotl1(input logic [N-1:0] v);
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[(i + 1) % N] = v[i];
    return r;
  endfunction

  rr_pick #(.N(N)) u_pick (
    .req (bus.req_in),
    .ptr (ptr_q),
    .gnt (pick)
  );

  // NOTE: every variable gets a default at the top of the block, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    grant   = '0;
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;

    if (bus.credit_ok) begin
      grant = (state_q == SA_IDLE) ? pick : (owner_q & bus.req_in);
    end

    // A tail (or single-flit packet) frees the port and rotates priority past
    // the winner; a head flit in IDLE dedicates the port to that input.
    if (|grant) begin
      if (|(grant & bus.tail_in)) begin
        state_d = SA_IDLE;
        owner_d = '0;
        ptr_d   = rotl1(grant);
      end else if (state_q == SA_IDLE) begin
        state_d = SA_LOCKED;
        owner_d = grant;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= SA_IDLE;
      ptr_q   <= N'(1);
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  assign bus.grant_out   = rstn ? grant : '0;
  assign bus.grant_valid = rstn & (|grant);
  assign bus.locked_out  = rstn & (state_q == SA_LOCKED);
  assign bus.owner_out   = rstn ? owner_q : '0;

`ifdef SA_OPORT_STALL_CNT_EN
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               would_grant;

  // Counts cycles where a flit was ready to move but the downstream had no credit.
  always_comb begin
    would_grant = (state_q == SA_IDLE) ? (|bus.req_in) : (|(owner_q & bus.req_in));
    stall_d     = stall_q;
    if (would_grant && !bus.credit_ok && (stall_q != '1)) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_sa_oport_arb.sv
// Directed table-driven bench for sa_oport_arb (N=5): one table row per clock.
module tb_sa_oport_arb;

  localparam int N = 5;

  logic clk;
  logic rstn;
  int   tests_run;
  int   tests_failed;

  sa_oport_arb_if #(.N(N)) bus ();

`ifdef SA_OPORT_STALL_CNT_EN
  logic [15:0] stall_cnt;
  sa_oport_arb #(.N(N), .STALL_W(16)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus.slave),
    .stall_cnt (stall_cnt)
  );
`else
  sa_oport_arb #(.N(N)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rstn;
    logic [N-1:0] req;
    logic [N-1:0] tail;
    logic         cr;
    logic [N-1:0] g;
    logic         l;
    logic [N-1:0] o;
    int           stall;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  function automatic vec_t mk(logic r, logic [N-1:0] req, logic [N-1:0] tail, logic cr,
                              logic [N-1:0] g, logic l, logic [N-1:0] o, int stall);
    vec_t v;
    v.rstn = r; v.req = req; v.tail = tail; v.cr = cr;
    v.g = g; v.l = l; v.o = o; v.stall = stall;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [N-1:0] req, input logic [N-1:0] tail,
                       input logic cr);
    rstn          = r;
    bus.req_in    = req;
    bus.tail_in   = tail;
    bus.credit_ok = cr;
  endtask

  task automatic expect_outs(input string tag, input logic [N-1:0] g, input logic l,
                             input logic [N-1:0] o);
    check({tag, " grant"},  32'(bus.grant_out),   32'(g));
    check({tag, " valid"},  32'(bus.grant_valid), 32'(|g));
    check({tag, " locked"}, 32'(bus.locked_out),  32'(l));
    check({tag, " owner"},  32'(bus.owner_out),   32'(o));
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    drive(1'b0, '0, '0, 1'b0);

    // Reset / reset priority / wrap / wormhole / credit stall / bubble / reset mid-packet
    vecs[0]  = mk(0, 5'b11111, 5'b11111, 1, 5'b00000, 0, 5'b00000, -1);
    vecs[1]  = mk(1, 5'b10110, 5'b11111, 1, 5'b00010, 0, 5'b00000, 0);
    vecs[2]  = mk(1, 5'b10110, 5'b11111, 1, 5'b00100, 0, 5'b00000, 0);
    vecs[3]  = mk(1, 5'b01000, 5'b11111, 1, 5'b01000, 0, 5'b00000, 0);
    vecs[4]  = mk(1, 5'b00011, 5'b11111, 1, 5'b00001, 0, 5'b00000, 0);
    vecs[5]  = mk(1, 5'b00011, 5'b11111, 1, 5'b00010, 0, 5'b00000, 0);
    vecs[6]  = mk(1, 5'b10101, 5'b00000, 1, 5'b00100, 0, 5'b00000, 0);
    vecs[7]  = mk(1, 5'b10101, 5'b00000, 1, 5'b00100, 1, 5'b00100, 0);
    vecs[8]  = mk(1, 5'b10101, 5'b00100, 1, 5'b00100, 1, 5'b00100, 0);
    vecs[9]  = mk(1, 5'b10001, 5'b11111, 1, 5'b10000, 0, 5'b00000, 0);
    vecs[10] = mk(1, 5'b00010, 5'b00000, 1, 5'b00010, 0, 5'b00000, 0);
    vecs[11] = mk(1, 5'b00011, 5'b00000, 0, 5'b00000, 1, 5'b00010, 0);
    vecs[12] = mk(1, 5'b00011, 5'b00000, 0, 5'b00000, 1, 5'b00010, 1);
    vecs[13] = mk(1, 5'b00011, 5'b00000, 0, 5'b00000, 1, 5'b00010, 2);
    vecs[14] = mk(1, 5'b00011, 5'b00000, 0, 5'b00000, 1, 5'b00010, 3);
    vecs[15] = mk(1, 5'b00011, 5'b00010, 1, 5'b00010, 1, 5'b00010, 4);
    vecs[16] = mk(1, 5'b01000, 5'b00000, 1, 5'b01000, 0, 5'b00000, 4);
    vecs[17] = mk(1, 5'b00111, 5'b11111, 1, 5'b00000, 1, 5'b01000, 4);
    vecs[18] = mk(1, 5'b00111, 5'b11111, 0, 5'b00000, 1, 5'b01000, 4);
    vecs[19] = mk(1, 5'b01000, 5'b01000, 1, 5'b01000, 1, 5'b01000, 4);
    vecs[20] = mk(1, 5'b10000, 5'b00000, 1, 5'b10000, 0, 5'b00000, 4);
    vecs[21] = mk(1, 5'b10000, 5'b00000, 1, 5'b10000, 1, 5'b10000, 4);
    vecs[22] = mk(0, 5'b10000, 5'b00000, 1, 5'b00000, 0, 5'b00000, -1);
    vecs[23] = mk(1, 5'b11111, 5'b11111, 1, 5'b00001, 0, 5'b00000, 0);
    vecs[24] = mk(1, 5'b11111, 5'b11111, 0, 5'b00000, 0, 5'b00000, 0);
    vecs[25] = mk(1, 5'b00000, 5'b11111, 1, 5'b00000, 0, 5'b00000, 1);

    @(posedge clk);
    #1;
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rstn, vecs[i].req, vecs[i].tail, vecs[i].cr);
      @(negedge clk);
      expect_outs($sformatf("vec%0d", i), vecs[i].g, vecs[i].l, vecs[i].o);
`ifdef SA_OPORT_STALL_CNT_EN
      if (vecs[i].stall >= 0)
        check($sformatf("vec%0d stall_cnt", i), 32'(stall_cnt), 32'(vecs[i].stall));
`endif
      @(posedge clk);
      #1;
    end

    // Lock input 2 (ptr is 5'b00010 here) and toggle credit under full contention;
    // non-owner tails must not release the lock.
    drive(1'b1, 5'b00100, 5'b00000, 1'b1);
    @(negedge clk);
    expect_outs("seq head", 5'b00100, 1'b0, 5'b00000);
    @(posedge clk);
    #1;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 5'b11111, 5'b11011, k[0]);
      @(negedge clk);
      expect_outs($sformatf("seq body%0d", k), k[0] ? 5'b00100 : 5'b00000, 1'b1, 5'b00100);
      @(posedge clk);
      #1;
    end
    drive(1'b1, 5'b11111, 5'b11111, 1'b1);
    @(negedge clk);
    expect_outs("seq tail", 5'b00100, 1'b1, 5'b00100);
    @(posedge clk);
    #1;
    @(negedge clk);
    expect_outs("seq release", 5'b01000, 1'b0, 5'b00000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sa_oport_arb.md
Name: sa_oport_arb

Overview:
- Output-port stage of the separable switch allocator. One instance per router output port.
- Arbitrates among the per-input-port requests that the input-port stages forward, and returns a one-hot grant.
- Wormhole lock: once a head flit wins, the output stays dedicated to that input until the tail flit has crossed.
- Round-robin fairness with priority update on packet completion. Grants are qualified by downstream credit availability.

Parameters:
- N, 5, number of router input ports (requesters); also the width of the request and grant vectors.
- STALL_W, 16, width of the stall counter (used only with the optional feature).

Ports:
- clk  input  1  router clock
- rstn  input  1  synchronous active-low reset
- req_in  input  N  bit i = input port i requests this output this cycle
- tail_in  input  N  bit i = the flit input i would send is a tail (or single-flit packet)
- credit_ok  input  1  downstream buffer has at least one credit
- grant_out  output  N  one-hot grant; flit transfers in every cycle where a bit is set
- grant_valid  output  1  equals the OR of grant_out
- locked_out  output  1  high while in LOCKED state
- owner_out  output  N  one-hot lock owner; 0 when IDLE
- stall_cnt  output  STALL_W  saturating stall count (present only when SA_OPORT_STALL_CNT_EN is defined)

Behaviour:
- Clocking and reset:
  - All state updates on the posedge of clk.
  - Reset is synchronous, active-low.
  - While rstn=0: state=IDLE, ptr=1 (input 0 highest priority), owner=0, stall_cnt=0.
  - While rstn=0, grant_out, grant_valid, locked_out and owner_out are forced to 0.
- grant_out is combinational from the current-cycle inputs and the registered state. Request-to-grant latency is 0 cycles; state update latency is 1 cycle.
- IDLE state:
  - If credit_ok=1 and req_in is nonzero: grant the first requester found searching from ptr upward with wrap-around (index N-1 wraps to 0).
  - If credit_ok=0 or req_in=0: grant_out=0.
- IDLE transitions on a grant to winner w:
  - tail_in[w]=0: next state LOCKED, owner<=onehot(w). ptr is unchanged.
  - tail_in[w]=1 (single-flit packet): stay IDLE, ptr<=onehot((w+1) mod N).
- LOCKED state:
  - grant_out = owner AND req_in, and only when credit_ok=1. All non-owner requests are ignored.
  - Owner request low (bubble) or credit_ok=0: grant_out=0, stay LOCKED. There is no timeout.
  - Owner granted with tail_in[owner]=1: next state IDLE, owner<=0, ptr<=onehot((owner+1) mod N).
  - Owner granted with tail_in=0: stay LOCKED.
- Invariants:
  - grant_out has at most one bit set.
  - A grant never issues when credit_ok=0.
  - owner_out is nonzero if and only if locked_out=1.
- Reset asserted mid-packet returns the block to IDLE immediately; the partial packet is abandoned (upstream flushes on the same reset).
- N=1: degenerate case. ptr is always 1; the lock still applies.

Optional Feature:
- Macro: SA_OPORT_STALL_CNT_EN.
- Defined:
  - stall_cnt increments in every cycle where a grant would otherwise issue (IDLE with req_in nonzero, or LOCKED with req_in[owner]=1) but credit_ok=0.
  - Saturates at 2^STALL_W-1 and never wraps.
  - Cleared only by reset.
- Not defined: the stall_cnt port and its counter logic are absent. Allocation behaviour is identical.

Decomposition:
- Shared package noc_sa_pkg:
  - Port count N and VC count V.
  - State encoding typedef: IDLE=1'b0, LOCKED=1'b1.
  - STALL_W default.
- Sub-module rr_pick: purely combinational round-robin selector.
  - Inputs: req[N-1:0], ptr[N-1:0] one-hot.
  - Output: one-hot grant.
  - Implementation: double-width masked priority encode.
  - Reused later by the VC allocator.

Test Plan:
- Reset priority:
  - Stimulus: after reset, req_in=5'b10110, credit_ok=1, tail_in=5'b11111.
  - Response: grant_out=5'b00010; next cycle ptr=5'b00100, so the same requests then grant 5'b00100.
- Wormhole lock:
  - Stimulus: input 2 sends a head flit (tail=0) while inputs 0 and 4 also request; input 2 holds req for 3 cycles, tail set on the 3rd.
  - Response: grant_out=5'b00100 for all 3 cycles and locked_out=1 for 2 of them; 4th cycle grants 5'b10000.
- Credit stall:
  - Stimulus: LOCKED, owner=1, credit_ok=0 for 4 cycles, then 1.
  - Response: grant_out=0 for 4 cycles; state stays LOCKED; stall_cnt=4 (feature on); grant 5'b00010 on resume.
- Owner bubble:
  - Stimulus: LOCKED, owner=3, req_in=5'b00111 (owner absent).
  - Response: grant_out=0 and locked_out stays 1.
- Wrap-around:
  - Stimulus: ptr=5'b10000, req_in=5'b00011, single-flit packets.
  - Response: grants 5'b00001, then 5'b00010.
- Reset mid-packet:
  - Stimulus: rstn=0 for 1 cycle while LOCKED with owner=4.
  - Response: next cycle locked_out=0, owner_out=0, ptr=5'b00001, stall_cnt=0.
